// File: rtl/id_ex_pkg.sv
// Shared types for the Decode->Execute skid register: control bundle, op layout and occupancy state.
package id_ex_pkg;

  localparam int ID_EX_DATA_W  = 24;
  localparam int ID_EX_RADDR_W = 4;
  localparam int ID_EX_CMD_W   = 4;

  typedef struct packed {
    logic mem_r_en;
    logic mem_w_en;
    logic wb_en;
    logic br_taken;
  } id_ex_ctrl_t;

  // Default-width op layout; the top rebuilds the same field order from its own parameters.
  typedef struct packed {
    id_ex_ctrl_t               ctrl;
    logic [ID_EX_CMD_W-1:0]    cmd;
    logic [ID_EX_RADDR_W-1:0]  src1;
    logic [ID_EX_RADDR_W-1:0]  src2;
    logic [ID_EX_RADDR_W-1:0]  dest;
    logic [ID_EX_DATA_W-1:0]   val1;
    logic [ID_EX_DATA_W-1:0]   val2;
    logic [ID_EX_DATA_W-1:0]   reg2;
  } id_ex_op_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  localparam id_ex_ctrl_t CTRL_NOP = '0;

  // A bubble must never write memory/RF or redirect fetch.
  function automatic id_ex_ctrl_t ctrl_gate(input id_ex_ctrl_t c, input logic vld);
    return vld ? c : CTRL_NOP;
  endfunction

endpackage

// File: rtl/id_ex_skid_reg_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter
  import id_ex_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/id_ex_skid_reg.sv
// Decode->Execute pipeline register with a 2-entry skid buffer, flush and stall counter.
module id_ex_skid_reg
  import id_ex_pkg::*;
#(
  parameter int DATA_W  = 24,
  parameter int RADDR_W = 4,
  parameter int CMD_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_ctrl,
  input  logic [CMD_W-1:0]   in_cmd,
  input  logic [RADDR_W-1:0] in_src1,
  input  logic [RADDR_W-1:0] in_src2,
  input  logic [RADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0]  in_val1,
  input  logic [DATA_W-1:0]  in_val2,
  input  logic [DATA_W-1:0]  in_reg2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_ctrl,
  output logic [CMD_W-1:0]   out_cmd,
  output logic [RADDR_W-1:0] out_src1,
  output logic [RADDR_W-1:0] out_src2,
  output logic [RADDR_W-1:0] out_dest,
  output logic [DATA_W-1:0]  out_val1,
  output logic [DATA_W-1:0]  out_val2,
  output logic [DATA_W-1:0]  out_reg2,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef struct packed {
    id_ex_ctrl_t        ctrl;
    logic [CMD_W-1:0]   cmd;
    logic [RADDR_W-1:0] src1;
    logic [RADDR_W-1:0] src2;
    logic [RADDR_W-1:0] dest;
    logic [DATA_W-1:0]  val1;
    logic [DATA_W-1:0]  val2;
    logic [DATA_W-1:0]  reg2;
  } op_t;

  op_t         in_op;
  op_t         main_op_p1;
  op_t         skid_op_p1;
  skid_state_e state_p1;
  logic        ready_p1;
  logic        accept;
  logic        pop;

  assign in_op = '{ctrl: id_ex_ctrl_t'(in_ctrl), cmd: in_cmd, src1: in_src1, src2: in_src2,
                   dest: in_dest, val1: in_val1, val2: in_val2, reg2: in_reg2};

  // Ready comes from a flop so Execute back-pressure never reaches Decode combinationally.
  assign in_ready  = ready_p1 & ~rst;
  assign out_valid = (state_p1 != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // ---- stage p1: occupancy FSM, main and skid slots ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1   <= EMPTY;
      ready_p1   <= 1'b1;
      main_op_p1 <= '0;
      skid_op_p1 <= '0;
    end else if (flush) begin
      state_p1 <= EMPTY;
      ready_p1 <= 1'b1;
    end else begin
      case (state_p1)
        EMPTY: begin
          if (accept) begin
            main_op_p1 <= in_op;
            state_p1   <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_op_p1 <= in_op;
          end else if (accept) begin
            skid_op_p1 <= in_op;
            state_p1   <= FULL;
            ready_p1   <= 1'b0;
          end else if (pop) begin
            state_p1 <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_op_p1 <= skid_op_p1;
            state_p1   <= ONE;
            ready_p1   <= 1'b1;
          end
        end
        default: begin
          state_p1 <= EMPTY;
          ready_p1 <= 1'b1;
        end
      endcase
    end
  end

  assign out_ctrl = ctrl_gate(main_op_p1.ctrl, out_valid);
  assign out_cmd  = main_op_p1.cmd;
  assign out_src1 = main_op_p1.src1;
  assign out_src2 = main_op_p1.src2;
  assign out_dest = main_op_p1.dest;
  assign out_val1 = main_op_p1.val1;
  assign out_val2 = main_op_p1.val2;
  assign out_reg2 = main_op_p1.reg2;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid & ~out_ready),
    .cnt (stall_cnt)
  );

endmodule
